sram_sp_arbiter: RTL and testbench

Controller that shares one single-port SRAM macro between a write requester and a read requester. The macro has active-low chip-enable and write-enable pins, one-cycle registered read data, and undefined Q on non-read cycles. The block arbitrates round-robin and drives the macro pins. Read data is captured into a 2-entry response FIFO with valid/ready backpressure. It sits between cache/predictor table logic and a black-box SRAM macro.

---
 rtl/sram_sp_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_sp_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arbiter.sv
// Round-robin write/read arbiter for a single-port SRAM macro, with a 2-entry read response FIFO.
// Optional SRAM_ZERO_INIT_EN: zero-fill sweep of the macro after reset before requests are served.
module sram_sp_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("ADDR_W must equal clog2(DEPTH)");
  end

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1 at the rising edge;
  // ready is combinational from valid and credit, and valid never waits on ready.
  logic              r_rd_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_cnt;
  logic              r_last_rd;
  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_occ;
  logic              w_rd_allow;
  logic              w_init_done;
  logic              w_wr_gnt;
  logic              w_rd_gnt;
  logic              w_rr_upd;

`ifdef SRAM_ZERO_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_addr;
  logic              w_init_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
  end

  // Pins stay idle while reset is held so the sweep only starts once reset is released.
  assign w_init_active = (r_state == ST_INIT) && !reset;
  assign w_init_done   = (r_state == ST_RUN);
`else
  assign w_init_done = 1'b1;
`endif

  assign resp_valid = (r_cnt != 2'd0);
  assign resp_data  = r_fifo[r_head];
  assign w_pop      = resp_valid && resp_ready;
  assign w_push     = r_rd_inflight;
  assign w_occ      = r_cnt + {1'b0, r_rd_inflight};
  assign w_rd_allow = (w_occ < 2'd2) || (w_occ == 2'd2 && w_pop);

  // A write forced by missing read credit leaves the round-robin pointer alone.
  always_comb begin
    w_wr_gnt = 1'b0;
    w_rd_gnt = 1'b0;
    w_rr_upd = 1'b0;
    if (w_init_done) begin
      if (wr_valid && rd_valid && w_rd_allow) begin
        w_rr_upd = 1'b1;
        if (r_last_rd) w_wr_gnt = 1'b1;
        else           w_rd_gnt = 1'b1;
      end else if (wr_valid) begin
        w_wr_gnt = 1'b1;
        w_rr_upd = !rd_valid;
      end else if (rd_valid && w_rd_allow) begin
        w_rd_gnt = 1'b1;
        w_rr_upd = 1'b1;
      end
    end
  end

  assign wr_ready  = w_wr_gnt;
  assign rd_ready  = w_rd_gnt;
  assign init_done = w_init_done;

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
`ifdef SRAM_ZERO_INIT_EN
    if (w_init_active) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = r_init_addr;
    end
`endif
    if (w_wr_gnt) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = wr_addr;
      sram_d   = wr_data;
    end else if (w_rd_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end
  end

  // Q is only captured in the cycle after a read grant; other cycles it is undefined.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_inflight <= 1'b0;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_cnt         <= 2'd0;
      r_last_rd     <= 1'b0;
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
    end else begin
      r_rd_inflight <= w_rd_gnt;
      if (w_push) begin
        r_fifo[r_tail] <= sram_q;
        r_tail         <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_rr_upd) r_last_rd <= w_rd_gnt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(w_push && !w_pop && r_cnt == 2'd2))
        else $error("response fifo overflow");
    end
  end
`endif

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural single-port SRAM model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_sram_sp_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, sram_a;
  logic [DW-1:0] wr_data, resp_data, sram_d, sram_q;
  logic          resp_valid, resp_ready, init_done, sram_ceb, sram_web;

  int            n_checks = 0;
  int            n_errs = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [32];

  sram_sp_arbiter #(.DATA_W(DW), .DEPTH(32), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // SRAM macro: registered Q on reads, undefined otherwise
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else                       sram_q <= 'x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errs++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic wait_init();
`ifdef SRAM_ZERO_INIT_EN
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      @(negedge clock);
      n++;
    end
    #1;
    chk("init_len", n, 32);
`else
    #1;
    chk("init_done", init_done, 1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
    wr_addr = 5'd7; rd_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    @(negedge clock); #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ceb", sram_ceb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_a", sram_a, 0);
    chk("rst_d", sram_d, 0);
    @(negedge clock);
    reset = 1'b0;
    wait_init();
  endtask

  // directed steps
  initial begin
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    @(negedge clock); #1;
    chk("rst_resp_data", resp_data, 0);
    do_reset();

    // write 3 then read 3 next cycle
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    #1;
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_wr_ceb", sram_ceb, 0);
    chk("t1_wr_web", sram_web, 0);
    chk("t1_wr_a", sram_a, 3);
    chk("t1_wr_d", sram_d, 32'hDEADBEEF);
    @(negedge clock);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd3;
    #1;
    chk("t1_rd_ready", rd_ready, 1);
    chk("t1_rd_web", sram_web, 1);
    chk("t1_rd_a", sram_a, 3);
    chk("t1_rd_d", sram_d, 0);
    @(negedge clock);
    rd_valid = 1'b0;
    #1;
    chk("t1_lat1_valid", resp_valid, 0);
    chk("t1_idle_ceb", sram_ceb, 1);
    @(negedge clock); #1;
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_data", resp_data, 32'hDEADBEEF);
    @(negedge clock);
    resp_ready = 1'b1;
    #1;
    chk("t1_hold_valid", resp_valid, 1);
    @(negedge clock); #1;
    chk("t1_drained", resp_valid, 0);

    // prefill 0..7, then back-to-back reads with resp_ready=1
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'h1000 + i;
      #1;
      chk("t2_fill_ready", wr_ready, 1);
    end
    @(negedge clock);
    wr_valid = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      rd_valid = (c < 8);
      rd_addr = AW'(c < 8 ? c : 0);
      #1;
      if (c < 8) begin
        chk("t2_rd_ready", rd_ready, 1);
        exp_q.push_back(32'h1000 + c);
      end
      chk("t2_resp_valid", resp_valid, (c >= 2 && c <= 9) ? 1 : 0);
      if (resp_valid && exp_q.size() > 0) chk("t2_resp_data", resp_data, exp_q.pop_front());
    end
    chk("t2_all_resp", exp_q.size(), 0);

    // backpressure: only two reads fit
    resp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      rd_valid = 1'b1; rd_addr = AW'(4 + c);
      #1;
      chk("t3_rd_ready", rd_ready, (c < 2) ? 1 : 0);
    end
    chk("t3_stall_ceb", sram_ceb, 1);
    chk("t3_full_valid", resp_valid, 1);
    chk("t3_full_data", resp_data, 32'h1004);
    @(negedge clock);
    resp_ready = 1'b1; rd_addr = 5'd7;
    #1;
    chk("t3_resume_ready", rd_ready, 1);
    chk("t3_pop0", resp_data, 32'h1004);
    @(negedge clock);
    rd_valid = 1'b0;
    #1;
    chk("t3_pop1_valid", resp_valid, 1);
    chk("t3_pop1", resp_data, 32'h1005);
    @(negedge clock); #1;
    chk("t3_pop2_valid", resp_valid, 1);
    chk("t3_pop2", resp_data, 32'h1007);
    @(negedge clock); #1;
    chk("t3_empty", resp_valid, 0);

    // round-robin alternation after reset
    do_reset();
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    #1;
    chk("t4_prewrite", wr_ready, 1);
    resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      wr_valid = (c < 8); wr_addr = 5'd10; wr_data = c;
      rd_valid = (c < 8); rd_addr = 5'd3;
      #1;
      if (c < 8) begin
        chk("t4_rd_ready", rd_ready, (c % 2 == 0) ? 1 : 0);
        chk("t4_wr_ready", wr_ready, (c % 2 == 1) ? 1 : 0);
        chk("t4_one_grant", {31'd0, rd_ready & wr_ready}, 0);
        chk("t4_web", sram_web, (c % 2 == 0) ? 1 : 0);
      end
      chk("t4_resp_valid", resp_valid, (c >= 2 && c <= 8 && c % 2 == 0) ? 1 : 0);
      if (c >= 2 && c <= 8 && c % 2 == 0) chk("t4_resp_data", resp_data, 32'hDEADBEEF);
    end

    // reset the cycle after a read is accepted
    @(negedge clock);
    rd_valid = 1'b1; rd_addr = 5'd3;
    #1;
    chk("t5_rd_ready", rd_ready, 1);
    @(negedge clock);
    rd_valid = 1'b0; reset = 1'b1;
    #1;
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_ceb", sram_ceb, 1);
    @(negedge clock);
    reset = 1'b0;
    wait_init();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      chk("t5_no_resp", resp_valid, 0);
      chk("t5_ceb", sram_ceb, 1);
      chk("t5_web", sram_web, 1);
    end

`ifdef SRAM_ZERO_INIT_EN
    @(negedge clock);
    rd_valid = 1'b1; rd_addr = 5'd20;
    #1;
    chk("z_rd_ready", rd_ready, 1);
    @(negedge clock);
    rd_valid = 1'b0;
    @(negedge clock); #1;
    chk("z_resp_valid", resp_valid, 1);
    chk("z_resp_zero", resp_data, 0);
    @(negedge clock);
    reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    chk("z_sweep_a10", sram_a, 10);
    chk("z_init_wr_ready", wr_ready, 0);
    chk("z_init_rd_ready", rd_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    #1;
    chk("z_restart_a0", sram_a, 0);
    chk("z_restart_ceb", sram_ceb, 0);
    chk("z_restart_web", sram_web, 0);
    wait_init();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
